// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel synchronise/debounce input register with rise/fall event pulses
module input_conditioner #(
    parameter int              WIDTH       = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              DEBOUNCE    = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    assign samp = sync[SYNC_STAGES-1];

    // Synchroniser stages reset to RESET_VALUE so that samp matches q on release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= RESET_VALUE;
            end
        end else begin
            sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    always_comb begin
        q_next    = q;
        rise_next = '0;
        fall_next = '0;
        for (int c = 0; c < WIDTH; c++) begin
            cnt_next[c] = cnt[c];
            if (load) begin
                q_next[c]   = load_value[c];
                cnt_next[c] = '0;
            end else if (enable) begin
                if (samp[c] == q[c]) begin
                    cnt_next[c] = '0;
                end else if (cnt[c] == CNT_LAST) begin
                    q_next[c]    = samp[c];
                    cnt_next[c]  = '0;
                    rise_next[c] = samp[c];
                    fall_next[c] = ~samp[c];
                end else begin
                    cnt_next[c] = cnt[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q       <= RESET_VALUE;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int c = 0; c < WIDTH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            q       <= q_next;
            rise    <= rise_next;
            fall    <= fall_next;
            changed <= |(rise_next | fall_next);
            for (int c = 0; c < WIDTH; c++) begin
                cnt[c] <= cnt_next[c];
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - table-driven self-checking bench for input_conditioner
module tb_input_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] d;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] model_q;

    input_conditioner #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE(8),
        .RESET_VALUE(4'b0101)
    ) dut (
        .clock(clock),
        .reset(reset),
        .d(d),
        .enable(enable),
        .load(load),
        .load_value(load_value),
        .q(q),
        .rise(rise),
        .fall(fall),
        .changed(changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs are held for 'cycles' edges; q must stay at its prior value with no
    // events until the last edge, where the expected outputs apply.
    typedef struct {
        logic [3:0] d;
        logic       en;
        logic       ld;
        logic [3:0] lv;
        int         cycles;
        logic [3:0] eq;
        logic [3:0] er;
        logic [3:0] ef;
        logic       ec;
    } entry_t;

    entry_t tbl [19];

    task automatic check(input string name, input int idx, input int cyc,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic [3:0] ef, input logic ec);
        n_checks++;
        if ({q, rise, fall, changed} !== {eq, er, ef, ec}) begin
            n_fail++;
            $display("FAIL %s entry=%0d cycle=%0d: got q=%b rise=%b fall=%b changed=%b, expected q=%b rise=%b fall=%b changed=%b",
                     name, idx, cyc, q, rise, fall, changed, eq, er, ef, ec);
        end
    endtask

    task automatic run_entry(input int k);
        d          = tbl[k].d;
        enable     = tbl[k].en;
        load       = tbl[k].ld;
        load_value = tbl[k].lv;
        for (int c = 1; c <= tbl[k].cycles; c++) begin
            @(posedge clock);
            #1;
            if (c < tbl[k].cycles)
                check("hold", k, c, model_q, 4'b0000, 4'b0000, 1'b0);
            else
                check("final", k, c, tbl[k].eq, tbl[k].er, tbl[k].ef, tbl[k].ec);
        end
        model_q = tbl[k].eq;
    endtask

    initial begin
        //           d        en    ld    lv       cyc  q        rise     fall     chg
        tbl[0]  = '{4'b0101, 1'b1, 1'b0, 4'b0000, 20, 4'b0101, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0111, 1'b1, 1'b0, 4'b0000, 10, 4'b0111, 4'b0010, 4'b0000, 1'b1};
        tbl[2]  = '{4'b0111, 1'b1, 1'b0, 4'b0000,  3, 4'b0111, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0000,  7, 4'b0111, 4'b0000, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0111, 1'b1, 1'b0, 4'b0000, 12, 4'b0111, 4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 10, 4'b1111, 4'b1000, 4'b0000, 1'b1};
        tbl[6]  = '{4'b1110, 1'b1, 1'b0, 4'b0000, 10, 4'b1110, 4'b0000, 4'b0001, 1'b1};
        tbl[7]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 10, 4'b0001, 4'b0001, 4'b1110, 1'b1};
        tbl[8]  = '{4'b0011, 1'b1, 1'b0, 4'b0000,  3, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0000,  5, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[10] = '{4'b0011, 1'b1, 1'b0, 4'b0000,  7, 4'b0011, 4'b0010, 4'b0000, 1'b1};
        tbl[11] = '{4'b0111, 1'b1, 1'b0, 4'b0000,  4, 4'b0011, 4'b0000, 4'b0000, 1'b0};
        tbl[12] = '{4'b0111, 1'b1, 1'b1, 4'b1010,  1, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b0111, 1'b1, 1'b0, 4'b0000,  8, 4'b0111, 4'b0101, 4'b1000, 1'b1};
        tbl[14] = '{4'b0111, 1'b0, 1'b1, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[15] = '{4'b0111, 1'b1, 1'b0, 4'b0000,  8, 4'b0111, 4'b0111, 4'b0000, 1'b1};
        tbl[16] = '{4'b1010, 1'b1, 1'b0, 4'b0000,  6, 4'b0111, 4'b0000, 4'b0000, 1'b0};
        tbl[17] = '{4'b1010, 1'b1, 1'b0, 4'b0000, 10, 4'b1010, 4'b1010, 4'b0101, 1'b1};
        tbl[18] = '{4'b1010, 1'b1, 1'b0, 4'b0000,  2, 4'b1010, 4'b0000, 4'b0000, 1'b0};

        reset      = 1'b1;
        d          = 4'b0101;
        enable     = 1'b1;
        load       = 1'b0;
        load_value = 4'b0000;
        model_q    = 4'b0101;
        repeat (3) @(posedge clock);
        #1;
        check("in_reset", -1, 0, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        #1;
        check("after_release", -1, 0, 4'b0101, 4'b0000, 4'b0000, 1'b0);

        for (int k = 0; k <= 16; k++) begin
            run_entry(k);
        end

        // Asynchronous reset mid-count: q must snap back without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", -1, 0, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_held", -1, 0, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        reset   = 1'b0;
        model_q = 4'b0101;

        for (int k = 17; k <= 18; k++) begin
            run_entry(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
